// File: rtl/mem_pkg.sv
// Shared types and constants for the activation buffer (mem) and its read ports.
package mem_pkg;

  localparam int DATA_W = 8;
  localparam int N_WE   = 4;

  typedef logic [DATA_W-1:0] byte_t;

  // Write ports beyond the enable vector share its last bit.
  function automatic int we_sel(input int port);
    return (port < N_WE) ? port : N_WE - 1;
  endfunction

endpackage

// File: rtl/mem_rd_port.sv
// Registered read port: one-cycle latency, cleared by synchronous reset.
module mem_rd_port
  import mem_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  byte_t data_i,
  output byte_t data_o
);

  byte_t data_q;
  byte_t data_d;

  // Next read value, forced to zero while in reset
  always_comb begin
    data_d = data_i;
    if (rst) begin
      data_d = '0;
    end else begin
      data_d = data_i;
    end
  end

  // Read data register
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/mem.sv
// Shared activation buffer: COLS_MAC write ports, COLS_MAC ofmap and INPUTS_MAC
// ifmap read ports, read-first. Optional macro MEM_PER_PORT_WE_EN gives per-port write enables.
module mem
  import mem_pkg::*;
#(
  parameter int ADDRESS_BITS = 8,
  parameter int COLS_MAC     = 4,
  parameter int INPUTS_MAC   = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  byte_t                   of_write     [0:COLS_MAC-1],
  input  logic [ADDRESS_BITS-1:0] of_w_address [0:COLS_MAC-1],
  output byte_t                   of_read      [0:COLS_MAC-1],
  input  logic [ADDRESS_BITS-1:0] of_r_address [0:COLS_MAC-1],
  output byte_t                   ifmap_r      [0:INPUTS_MAC-1],
  input  logic [ADDRESS_BITS-1:0] if_address   [0:INPUTS_MAC-1],
  input  logic                    en_w         [0:N_WE-1]
);

  localparam int DEPTH = 1 << ADDRESS_BITS;

  byte_t               mem_q [0:DEPTH-1];
  byte_t               mem_d [0:DEPTH-1];
  logic [COLS_MAC-1:0] port_we_s;

`ifdef MEM_PER_PORT_WE_EN
  for (genvar i = 0; i < COLS_MAC; i++) begin : g_we
    assign port_we_s[i] = en_w[we_sel(i)];
  end
`else
  logic unused_en_s;
  assign port_we_s   = {COLS_MAC{en_w[0]}};
  assign unused_en_s = en_w[1] ^ en_w[2] ^ en_w[3];
`endif

  // Apply writes in ascending port order so the highest port wins a collision
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < COLS_MAC; i++) begin
      mem_d[of_w_address[i]] = port_we_s[i] ? of_write[i] : mem_d[of_w_address[i]];
    end
  end

  // Storage register; reset clears every byte and drops that cycle's writes
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read ports sample the pre-write array, giving read-first behaviour
  for (genvar i = 0; i < COLS_MAC; i++) begin : g_of_rd
    mem_rd_port u_rd (
      .clk    (clk),
      .rst    (rst),
      .data_i (mem_q[of_r_address[i]]),
      .data_o (of_read[i])
    );
  end

  for (genvar j = 0; j < INPUTS_MAC; j++) begin : g_if_rd
    mem_rd_port u_rd (
      .clk    (clk),
      .rst    (rst),
      .data_i (mem_q[if_address[j]]),
      .data_o (ifmap_r[j])
    );
  end

endmodule

// File: tb/tb_mem.sv
// Self-checking bench for mem: directed scenarios plus a randomized run
// against a byte-array reference model.
module tb_mem;

  localparam int AW = 8;
  localparam int NC = 4;
  localparam int NI = 6;

  logic          clk;
  logic          rst;
  logic [7:0]    of_write     [0:NC-1];
  logic [AW-1:0] of_w_address [0:NC-1];
  logic [7:0]    of_read      [0:NC-1];
  logic [AW-1:0] of_r_address [0:NC-1];
  logic [7:0]    ifmap_r      [0:NI-1];
  logic [AW-1:0] if_address   [0:NI-1];
  logic          en_w         [0:3];

  int checks   = 0;
  int failures = 0;

  logic [7:0] model  [0:(1<<AW)-1];
  logic [7:0] exp_of [0:NC-1];
  logic [7:0] exp_if [0:NI-1];

  mem #(.ADDRESS_BITS(AW), .COLS_MAC(NC), .INPUTS_MAC(NI)) dut (
    .clk          (clk),
    .rst          (rst),
    .of_write     (of_write),
    .of_w_address (of_w_address),
    .of_read      (of_read),
    .of_r_address (of_r_address),
    .ifmap_r      (ifmap_r),
    .if_address   (if_address),
    .en_w         (en_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic port_en(input int i);
`ifdef MEM_PER_PORT_WE_EN
    return en_w[(i < 4) ? i : 3];
`else
    return en_w[0];
`endif
  endfunction

  // One clock: expected reads come from the model before this edge's writes.
  task automatic step();
    for (int i = 0; i < NC; i++) exp_of[i] = rst ? 8'd0 : model[of_r_address[i]];
    for (int j = 0; j < NI; j++) exp_if[j] = rst ? 8'd0 : model[if_address[j]];
    if (rst) begin
      for (int a = 0; a < (1 << AW); a++) model[a] = 8'd0;
    end else begin
      for (int i = 0; i < NC; i++) if (port_en(i)) model[of_w_address[i]] = of_write[i];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic e0, input logic e1, input logic e2, input logic e3);
    en_w[0] = e0; en_w[1] = e1; en_w[2] = e2; en_w[3] = e3;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_en(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      for (int i = 0; i < NC; i++) of_r_address[i] = AW'(a);
      for (int j = 0; j < NI; j++) if_address[j] = AW'(a);
      step();
      for (int i = 0; i < NC; i++) begin
        checks++;
        if (of_read[i] !== 8'd0) begin
          failures++;
          $display("FAIL reset_of[%0d] addr %0d: got %0d expected 0", i, a, of_read[i]);
        end
      end
      for (int j = 0; j < NI; j++) begin
        checks++;
        if (ifmap_r[j] !== 8'd0) begin
          failures++;
          $display("FAIL reset_if[%0d] addr %0d: got %0d expected 0", j, a, ifmap_r[j]);
        end
      end
    end
  endtask

  task automatic test_parallel_write();
    logic [7:0] want [0:NC-1];
    want[0] = 8'd1; want[1] = 8'd2; want[2] = 8'd3; want[3] = 8'd4;
    for (int i = 0; i < NC; i++) begin
      of_w_address[i] = AW'(i);
      of_write[i]     = 8'(i + 1);
    end
    set_en(1'b1, 1'b1, 1'b1, 1'b1);
    step();
    set_en(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NC; i++) of_r_address[i] = AW'(i);
    step();
    for (int i = 0; i < NC; i++) begin
      checks++;
      if (of_read[i] !== want[i]) begin
        failures++;
        $display("FAIL parallel_of[%0d]: got %0d expected %0d", i, of_read[i], want[i]);
      end
    end
  endtask

  task automatic test_cross_port();
    logic [7:0] want [0:NI-1];
    want[0] = 8'd3; want[1] = 8'd4; want[2] = 8'd10;
    want[3] = 8'd11; want[4] = 8'd12; want[5] = 8'd13;
    for (int i = 0; i < NC; i++) begin
      of_w_address[i] = AW'(i + 4);
      of_write[i]     = 8'(i + 10);
    end
    set_en(1'b1, 1'b1, 1'b1, 1'b1);
    step();
    set_en(1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < NI; j++) if_address[j] = AW'(j + 2);
    step();
    for (int j = 0; j < NI; j++) begin
      checks++;
      if (ifmap_r[j] !== want[j]) begin
        failures++;
        $display("FAIL cross_if[%0d]: got %0d expected %0d", j, ifmap_r[j], want[j]);
      end
    end
  endtask

  task automatic test_disabled_write();
    for (int i = 0; i < NC; i++) begin
      of_w_address[i] = AW'(i);
      of_write[i]     = 8'd99;
      of_r_address[i] = AW'(i);
    end
`ifdef MEM_PER_PORT_WE_EN
    set_en(1'b0, 1'b0, 1'b0, 1'b0);
`else
    set_en(1'b0, 1'b1, 1'b1, 1'b1);
`endif
    step();
    set_en(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < NC; i++) begin
      checks++;
      if (of_read[i] !== 8'(i + 1)) begin
        failures++;
        $display("FAIL disabled_of[%0d]: got %0d expected %0d", i, of_read[i], i + 1);
      end
    end
  endtask

  task automatic test_collision();
    of_w_address[0] = AW'(9);  of_write[0] = 8'd20;
    of_w_address[1] = AW'(20); of_write[1] = 8'd5;
    of_w_address[2] = AW'(21); of_write[2] = 8'd6;
    of_w_address[3] = AW'(9);  of_write[3] = 8'd30;
    for (int i = 0; i < NC; i++) of_r_address[i] = AW'(9);
    set_en(1'b1, 1'b1, 1'b1, 1'b1);
    step();
    set_en(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (of_read[0] !== 8'd0) begin
      failures++;
      $display("FAIL collision_read_first: got %0d expected 0", of_read[0]);
    end
    step();
    for (int i = 0; i < NC; i++) begin
      checks++;
      if (of_read[i] !== 8'd30) begin
        failures++;
        $display("FAIL collision_winner[%0d]: got %0d expected 30", i, of_read[i]);
      end
    end
  endtask

`ifdef MEM_PER_PORT_WE_EN
  task automatic test_per_port();
    logic [7:0] want [0:NC-1];
    want[0] = 8'd0; want[1] = 8'd2; want[2] = 8'd0; want[3] = 8'd0;
    for (int i = 0; i < NC; i++) begin
      of_w_address[i] = AW'(i + 30);
      of_write[i]     = 8'(i + 1);
      of_r_address[i] = AW'(i + 30);
    end
    set_en(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    set_en(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < NC; i++) begin
      checks++;
      if (of_read[i] !== want[i]) begin
        failures++;
        $display("FAIL per_port_of[%0d]: got %0d expected %0d", i, of_read[i], want[i]);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    for (int i = 0; i < NC; i++) begin
      of_w_address[i] = AW'(i);
      of_write[i]     = 8'd55;
      of_r_address[i] = AW'(i + 4);
    end
    rst = 1'b1;
    set_en(1'b1, 1'b1, 1'b1, 1'b1);
    step();
    rst = 1'b0;
    set_en(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NC; i++) begin
      checks++;
      if (of_read[i] !== 8'd0) begin
        failures++;
        $display("FAIL reset_mid_out[%0d]: got %0d expected 0", i, of_read[i]);
      end
    end
    for (int a = 0; a < 12; a += 4) begin
      for (int i = 0; i < NC; i++) of_r_address[i] = AW'(a + i);
      for (int j = 0; j < NI; j++) if_address[j] = AW'(a + j);
      step();
      for (int i = 0; i < NC; i++) begin
        checks++;
        if (of_read[i] !== 8'd0) begin
          failures++;
          $display("FAIL reset_mid_of[%0d] addr %0d: got %0d expected 0", i, a + i, of_read[i]);
        end
      end
      for (int j = 0; j < NI; j++) begin
        checks++;
        if (ifmap_r[j] !== 8'd0) begin
          failures++;
          $display("FAIL reset_mid_if[%0d] addr %0d: got %0d expected 0", j, a + j, ifmap_r[j]);
        end
      end
    end
  endtask

  // Narrow address range forces frequent collisions and read-during-write.
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 40) == 0);
      set_en(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      for (int i = 0; i < NC; i++) begin
        of_w_address[i] = AW'($urandom_range(0, 15));
        of_write[i]     = 8'($urandom);
        of_r_address[i] = AW'($urandom_range(0, 15));
      end
      for (int j = 0; j < NI; j++) if_address[j] = AW'($urandom_range(0, 15));
      step();
      for (int i = 0; i < NC; i++) begin
        checks++;
        if (of_read[i] !== exp_of[i]) begin
          failures++;
          $display("FAIL rand_of[%0d] cycle %0d: got %0d expected %0d", i, c, of_read[i], exp_of[i]);
        end
      end
      for (int j = 0; j < NI; j++) begin
        checks++;
        if (ifmap_r[j] !== exp_if[j]) begin
          failures++;
          $display("FAIL rand_if[%0d] cycle %0d: got %0d expected %0d", j, c, ifmap_r[j], exp_if[j]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_en(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NC; i++) begin
      of_write[i] = 8'd0; of_w_address[i] = '0; of_r_address[i] = '0;
    end
    for (int j = 0; j < NI; j++) if_address[j] = '0;
    for (int a = 0; a < (1 << AW); a++) model[a] = 8'd0;
    #1;
    test_reset();
    test_parallel_write();
    test_cross_port();
    test_disabled_write();
    test_collision();
`ifdef MEM_PER_PORT_WE_EN
    test_per_port();
`endif
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem.md
Name: mem

Overview:
- Shared on-chip activation buffer for the CNN/FC accelerator: 2^ADDRESS_BITS bytes.
- Written by the MAC column outputs (ofmap write ports).
- Read back both as ofmap (COLS_MAC ports) and as ifmap for the next layer (INPUTS_MAC ports).
- All ports address the same storage, so one layer's output becomes the next layer's input without copying.

Parameters:
- ADDRESS_BITS, 8, address width; depth = 2^ADDRESS_BITS bytes.
- COLS_MAC, 4, number of MAC columns; count of write ports and ofmap read ports.
- INPUTS_MAC, 6, number of MAC inputs; count of ifmap read ports.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- of_write  in  8 x [0:COLS_MAC-1] unpacked  write data per column.
- of_w_address  in  ADDRESS_BITS x [0:COLS_MAC-1]  write address per column.
- of_read  out  8 x [0:COLS_MAC-1]  ofmap read data.
- of_r_address  in  ADDRESS_BITS x [0:COLS_MAC-1]  ofmap read address.
- ifmap_r  out  8 x [0:INPUTS_MAC-1]  ifmap read data.
- if_address  in  ADDRESS_BITS x [0:INPUTS_MAC-1]  ifmap read address.
- en_w  in  1 x [0:3] unpacked  write-enable vector.

Behaviour:
- Storage: 2^ADDRESS_BITS x 8-bit array.
- Reset: on a posedge with rst=1:
  - every storage byte is cleared to 0;
  - all of_read[] and ifmap_r[] registers are cleared to 0;
  - writes in that cycle are ignored.
- Write (default build):
  - on a posedge with rst=0 and en_w[0]=1, every port i in 0..COLS_MAC-1 writes mem[of_w_address[i]] <= of_write[i];
  - en_w[1..3] are ignored.
- Write collision: when several ports target the same address in one cycle, the highest port index wins.
- Read timing:
  - registered, 1-cycle latency;
  - of_read[i] <= mem[of_r_address[i]] and ifmap_r[j] <= mem[if_address[j]] every posedge with rst=0;
  - no read enable.
- Read-during-write to the same address: read-first; the read returns the pre-write byte, and the new value is visible one cycle later.
- Addresses are always in range (full 2^ADDRESS_BITS decode); no wrap logic needed.
- No arithmetic; data is passed through unchanged.

Optional Feature:
- Macro: MEM_PER_PORT_WE_EN.
- Defined: en_w[i] gates write port i individually, for i < min(COLS_MAC,4); ports with index >= 4 follow en_w[3].
- Undefined: en_w[0] is the common write enable for all ports, as described above.
- All other behaviour is identical in both builds.

Decomposition:
- Package mem_pkg:
  - DATA_W = 8;
  - N_WE = 4 (en_w length);
  - typedef byte_t (logic [DATA_W-1:0]).
- One sub-module, mem_rd_port: a registered read port with synchronous clear.
  - Instantiated COLS_MAC times for of_read and INPUTS_MAC times for ifmap_r.
  - The storage array and write logic stay in mem.

Test Plan:
1. Reset: rst=1 for 1 cycle, then read all addresses 0..7 on every port -> all of_read/ifmap_r = 0 one cycle after each address is applied.
2. Parallel write and read: en_w[0]=1 with of_w_address={0,1,2,3} and of_write={1,2,3,4} for one cycle, then en_w[0]=0 and of_r_address={0,1,2,3} -> of_read={1,2,3,4} after 1 cycle.
3. Second write and cross-port read: write addresses {4,5,6,7} with {10,11,12,13}, then if_address={2..7} -> ifmap_r={3,4,10,11,12,13} one cycle later.
4. Disabled write: en_w[0]=0, of_write={99,99,99,99} to addresses {0..3} -> reads of addresses 0..3 still return {1,2,3,4}.
5. Collision and read-first:
   - ports 0 and 3 both write address 9 with 20 and 30 -> address 9 reads 30;
   - in the same cycle, read address 9 -> returns old value 0; the next cycle returns 30.
6. Reset mid-operation: with data loaded, assert rst together with en_w[0]=1 -> the write is dropped and all reads return 0 afterwards. With MEM_PER_PORT_WE_EN: en_w={0,1,0,0} -> only port 1's address is updated.
